// File: rtl/sdram_read_pkg.sv
// Shared SDRAM definitions: command encodings, default timing and bus field widths.
// The file name follows the block; the package itself is sdram_pkg, shared by the controller.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS        = 4'b0000;

  localparam int DEF_CL   = 3;
  localparam int DEF_TRCD = 2;
  localparam int DEF_TRP  = 2;

  localparam int BA_W  = 2;
  localparam int ROW_W = 11;
  localparam int COL_W = 8;
  localparam int DQ_W  = 32;

  localparam logic [BA_W-1:0]  IDLE_BA   = 2'b11;
  localparam logic [ROW_W-1:0] IDLE_ADDR = 11'h7ff;

endpackage

// File: rtl/sdram_read.sv
// Read engine: ACTIVE, tRCD, full-page READ cut short by BURST STOP, PRECHARGE, tRP.
// Returned DQ words are registered and strobed towards the read FIFO via rd_ack.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int CL       = DEF_CL,
  parameter int TRCD_CLK = DEF_TRCD,
  parameter int TRP_CLK  = DEF_TRP
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              rd_en,
  input  logic [20:0]       rd_addr,
  input  logic [8:0]        rd_burst_len,
  input  logic [DQ_W-1:0]   rd_data_in,
  output logic              rd_end,
  output logic [3:0]        rd_cmd,
  output logic [BA_W-1:0]   rd_ba,
  output logic [ROW_W-1:0]  rd_sdram_addr,
  output logic              rd_ack,
  output logic [DQ_W-1:0]   rd_sdram_data
);

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_ACTIVE = 8'b0000_0010,
    S_TRCD   = 8'b0000_0100,
    S_READ   = 8'b0000_1000,
    S_RDDATA = 8'b0001_0000,
    S_PRE    = 8'b0010_0000,
    S_TRP    = 8'b0100_0000,
    S_END    = 8'b1000_0000
  } state_e;

  localparam logic [9:0] CL_W      = 10'(CL);
  localparam logic [7:0] TRCD_LAST = 8'(TRCD_CLK - 1);
  localparam logic [7:0] TRP_LAST  = 8'(TRP_CLK - 1);

  state_e             state_q;
  logic [7:0]         cntClk_q;
  logic [9:0]         cntRd_q;
  logic [BA_W-1:0]    bank_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   col_q;
  logic [8:0]         len_q;
  logic [3:0]         cmd_q;
  logic [BA_W-1:0]    ba_q;
  logic [ROW_W-1:0]   addr_q;
  logic               end_q;
  logic               ack_q;
  logic [DQ_W-1:0]    data_q;

  logic [8:0]         lenClamp_d;
  logic [9:0]         cntRd_d;
  logic [9:0]         rdLast;
  logic               dqValid;

  // A full page is 256 columns, so both 0 and anything beyond 256 mean "whole page".
  assign lenClamp_d = (rd_burst_len == 9'd0 || rd_burst_len > 9'd256) ? 9'd256 : rd_burst_len;
  assign cntRd_d    = cntRd_q + 10'd1;
  assign rdLast     = CL_W + {1'b0, len_q} - 10'd1;
  assign dqValid    = (state_q == S_RDDATA) && (cntRd_q >= CL_W) && (cntRd_q <= rdLast);

  // Command/address registers are loaded alongside the state they belong to,
  // so every output is a flop and nothing leaks combinationally from the inputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cntClk_q <= '0;
      cntRd_q  <= '0;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      len_q    <= '0;
      cmd_q    <= CMD_NOP;
      ba_q     <= IDLE_BA;
      addr_q   <= IDLE_ADDR;
      end_q    <= 1'b0;
      ack_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      cmd_q  <= CMD_NOP;
      ba_q   <= IDLE_BA;
      addr_q <= IDLE_ADDR;
      end_q  <= 1'b0;
      ack_q  <= dqValid;
      if (dqValid) data_q <= rd_data_in;

      case (state_q)
        S_IDLE: begin
          if (init_end && rd_en) begin
            state_q <= S_ACTIVE;
            bank_q  <= rd_addr[20:19];
            row_q   <= rd_addr[18:8];
            col_q   <= rd_addr[7:0];
            len_q   <= lenClamp_d;
            cmd_q   <= CMD_ACTIVE;
            ba_q    <= rd_addr[20:19];
            addr_q  <= rd_addr[18:8];
          end
        end
        S_ACTIVE: begin
          state_q  <= S_TRCD;
          cntClk_q <= '0;
        end
        S_TRCD: begin
          if (cntClk_q == TRCD_LAST) begin
            state_q  <= S_READ;
            cntClk_q <= '0;
            cntRd_q  <= '0;
            cmd_q    <= CMD_READ;
            ba_q     <= bank_q;
            addr_q   <= {3'b000, col_q};
          end else begin
            cntClk_q <= cntClk_q + 8'd1;
          end
        end
        S_READ: begin
          state_q <= S_RDDATA;
          cntRd_q <= cntRd_d;
          if (cntRd_d == {1'b0, len_q}) cmd_q <= CMD_BURST_STOP;
        end
        S_RDDATA: begin
          cntRd_q <= cntRd_d;
          if (cntRd_q == rdLast) begin
            state_q <= S_PRE;
            cmd_q   <= CMD_PRECHARGE;
            ba_q    <= 2'b00;
            addr_q  <= 11'h400;
          end else if (cntRd_d == {1'b0, len_q}) begin
            cmd_q <= CMD_BURST_STOP;
          end
        end
        S_PRE: begin
          state_q  <= S_TRP;
          cntClk_q <= '0;
          cntRd_q  <= '0;
        end
        S_TRP: begin
          if (cntClk_q == TRP_LAST) begin
            state_q  <= S_END;
            cntClk_q <= '0;
            end_q    <= 1'b1;
          end else begin
            cntClk_q <= cntClk_q + 8'd1;
          end
        end
        S_END: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_end        = end_q;
  assign rd_cmd        = cmd_q;
  assign rd_ba         = ba_q;
  assign rd_sdram_addr = addr_q;
  assign rd_ack        = ack_q;
  assign rd_sdram_data = data_q;

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read: per-cycle trace of each transaction checked against
// hand-computed cycle numbers (cycle 0 = cycle in which rd_en is first presented).
module tb_sdram_read;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_BST = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end;
  logic        rd_en;
  logic [20:0] rd_addr;
  logic [8:0]  rd_burst_len;
  logic [31:0] rd_data_in;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [10:0] rd_sdram_addr;
  logic        rd_ack;
  logic [31:0] rd_sdram_data;

  int errors = 0;
  int checks = 0;

  logic [3:0]  tCmd  [0:299];
  logic [1:0]  tBa   [0:299];
  logic [10:0] tAddr [0:299];
  logic        tAck  [0:299];
  logic [31:0] tData [0:299];
  logic        tEnd  [0:299];

  sdram_read dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .init_end     (init_end),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_data_in   (rd_data_in),
    .rd_end       (rd_end),
    .rd_cmd       (rd_cmd),
    .rd_ba        (rd_ba),
    .rd_sdram_addr(rd_sdram_addr),
    .rd_ack       (rd_ack),
    .rd_sdram_data(rd_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  // Word the DQ model drives during trace cycle c.
  function automatic logic [31:0] dqWord(input int c);
    return {16'hDA7A, 16'(c)};
  endfunction

  // Present a request at a negedge and record outputs once per cycle, sampled at negedges.
  task automatic runRead(input logic [20:0] addr, input logic [8:0] len, input int dropAt,
                         input bit clearOnEnd, input int nCyc);
    for (int i = 0; i < 300; i++) begin
      tCmd[i] = C_NOP; tBa[i] = 2'b11; tAddr[i] = 11'h7ff;
      tAck[i] = 1'b0; tData[i] = '0; tEnd[i] = 1'b0;
    end
    rd_addr = addr;
    rd_burst_len = len;
    rd_en = 1'b1;
    rd_data_in = dqWord(0);
    for (int c = 1; c <= nCyc; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      tCmd[c] = rd_cmd; tBa[c] = rd_ba; tAddr[c] = rd_sdram_addr;
      tAck[c] = rd_ack; tData[c] = rd_sdram_data; tEnd[c] = rd_end;
      rd_data_in = dqWord(c);
      if (c == dropAt) rd_en = 1'b0;
      if (clearOnEnd && rd_end) rd_en = 1'b0;
    end
  endtask

  function automatic void ackStats(output int first, output int last, output int count,
                                   output int dataBad);
    first = -1; last = -1; count = 0; dataBad = 0;
    for (int c = 1; c < 300; c++) begin
      if (tAck[c] === 1'b1) begin
        count++;
        if (first < 0) first = c;
        last = c;
        if (tData[c] !== dqWord(c - 1)) dataBad++;
      end
    end
  endfunction

  function automatic void endStats(output int count, output int firstAt);
    count = 0; firstAt = -1;
    for (int c = 1; c < 300; c++) begin
      if (tEnd[c] === 1'b1) begin
        count++;
        if (firstAt < 0) firstAt = c;
      end
    end
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0; init_end = 1'b0; rd_en = 1'b1;
    rd_addr = 21'h1f_ffff; rd_burst_len = 9'd4; rd_data_in = 32'hFFFF_FFFF;
    #12;
    checks++; if (rd_cmd !== C_NOP) begin errors++; $display("[TB] FAIL reset_cmd: got %b expected %b", rd_cmd, C_NOP); end
    checks++; if (rd_ba !== 2'b11) begin errors++; $display("[TB] FAIL reset_ba: got %b expected 11", rd_ba); end
    checks++; if (rd_sdram_addr !== 11'h7ff) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 7ff", rd_sdram_addr); end
    checks++; if (rd_ack !== 1'b0 || rd_end !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got ack=%b end=%b expected 0/0", rd_ack, rd_end); end
    checks++; if (rd_sdram_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", rd_sdram_data); end
    #5 sys_rst_n = 1'b1;
    // init_end low: a held grant must be ignored.
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      checks++; if (rd_cmd !== C_NOP || rd_ba !== 2'b11 || rd_sdram_addr !== 11'h7ff || rd_ack !== 1'b0 || rd_end !== 1'b0) begin
        errors++; $display("[TB] FAIL noinit_idle[%0d]: got cmd=%b ba=%b addr=%h ack=%b end=%b expected 0111/11/7ff/0/0", c, rd_cmd, rd_ba, rd_sdram_addr, rd_ack, rd_end);
      end
    end
    rd_en = 1'b0;
    init_end = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_basic();
    logic [3:0] expCmd [1:15];
    int first, last, count, dataBad, endCnt, endAt;
    expCmd = '{C_ACT, C_NOP, C_NOP, C_RD, C_NOP, C_NOP, C_NOP, C_BST,
               C_NOP, C_NOP, C_PRE, C_NOP, C_NOP, C_NOP, C_NOP};
    runRead({2'b10, 11'h123, 8'h40}, 9'd4, -1, 1'b1, 18);
    for (int c = 1; c <= 15; c++) begin
      checks++; if (tCmd[c] !== expCmd[c]) begin errors++; $display("[TB] FAIL basic_cmd[%0d]: got %b expected %b", c, tCmd[c], expCmd[c]); end
    end
    checks++; if (tBa[1] !== 2'b10 || tAddr[1] !== 11'h123) begin errors++; $display("[TB] FAIL basic_act_addr: got ba=%b addr=%h expected 10/123", tBa[1], tAddr[1]); end
    checks++; if (tBa[4] !== 2'b10 || tAddr[4] !== 11'h040) begin errors++; $display("[TB] FAIL basic_read_addr: got ba=%b addr=%h expected 10/040", tBa[4], tAddr[4]); end
    checks++; if (tBa[11] !== 2'b00 || tAddr[11] !== 11'h400) begin errors++; $display("[TB] FAIL basic_pre_addr: got ba=%b addr=%h expected 00/400", tBa[11], tAddr[11]); end
    checks++; if (tBa[15] !== 2'b11 || tAddr[15] !== 11'h7ff) begin errors++; $display("[TB] FAIL basic_idle_bus: got ba=%b addr=%h expected 11/7ff", tBa[15], tAddr[15]); end
    ackStats(first, last, count, dataBad);
    checks++; if (first !== 8 || last !== 11 || count !== 4) begin errors++; $display("[TB] FAIL basic_ack_window: got first=%0d last=%0d count=%0d expected 8/11/4", first, last, count); end
    checks++; if (tData[8] !== dqWord(7) || tData[11] !== dqWord(10)) begin errors++; $display("[TB] FAIL basic_data: got %h,%h expected %h,%h", tData[8], tData[11], dqWord(7), dqWord(10)); end
    checks++; if (dataBad !== 0) begin errors++; $display("[TB] FAIL basic_data_all: got %0d bad words expected 0", dataBad); end
    endStats(endCnt, endAt);
    checks++; if (endCnt !== 1 || endAt !== 14) begin errors++; $display("[TB] FAIL basic_end: got count=%0d at=%0d expected 1 at 14", endCnt, endAt); end
  endtask

  task automatic test_len1();
    int first, last, count, dataBad, endCnt, endAt;
    runRead({2'b01, 11'h055, 8'hFF}, 9'd1, -1, 1'b1, 14);
    checks++; if (tCmd[4] !== C_RD || tAddr[4] !== 11'h0ff) begin errors++; $display("[TB] FAIL len1_read: got cmd=%b addr=%h expected 0101/0ff", tCmd[4], tAddr[4]); end
    checks++; if (tCmd[5] !== C_BST) begin errors++; $display("[TB] FAIL len1_bst: got %b expected %b", tCmd[5], C_BST); end
    checks++; if (tCmd[8] !== C_PRE) begin errors++; $display("[TB] FAIL len1_pre: got %b expected %b", tCmd[8], C_PRE); end
    ackStats(first, last, count, dataBad);
    checks++; if (first !== 8 || count !== 1 || dataBad !== 0) begin errors++; $display("[TB] FAIL len1_ack: got first=%0d count=%0d bad=%0d expected 8/1/0", first, count, dataBad); end
    endStats(endCnt, endAt);
    checks++; if (endCnt !== 1 || endAt !== 11) begin errors++; $display("[TB] FAIL len1_end: got count=%0d at=%0d expected 1 at 11", endCnt, endAt); end
  endtask

  task automatic test_full_page(input logic [8:0] len);
    int first, last, count, dataBad, endCnt, endAt, bstCnt;
    runRead({2'b11, 11'h7fe, 8'h00}, len, -1, 1'b1, 270);
    bstCnt = 0;
    for (int c = 1; c < 300; c++) if (tCmd[c] === C_BST) bstCnt++;
    checks++; if (tCmd[260] !== C_BST || bstCnt !== 1) begin errors++; $display("[TB] FAIL page%0d_bst: got cmd=%b count=%0d expected BST once at 260", len, tCmd[260], bstCnt); end
    ackStats(first, last, count, dataBad);
    checks++; if (count !== 256 || first !== 8 || last !== 263) begin errors++; $display("[TB] FAIL page%0d_acks: got count=%0d first=%0d last=%0d expected 256/8/263", len, count, first, last); end
    checks++; if (dataBad !== 0) begin errors++; $display("[TB] FAIL page%0d_data: got %0d bad words expected 0", len, dataBad); end
    checks++; if (tCmd[263] !== C_PRE) begin errors++; $display("[TB] FAIL page%0d_pre: got %b expected %b", len, tCmd[263], C_PRE); end
    endStats(endCnt, endAt);
    checks++; if (endCnt !== 1 || endAt !== 266) begin errors++; $display("[TB] FAIL page%0d_end: got count=%0d at=%0d expected 1 at 266", len, endCnt, endAt); end
  endtask

  task automatic test_drop();
    int first, last, count, dataBad, endCnt, endAt;
    runRead({2'b00, 11'h001, 8'h10}, 9'd8, 3, 1'b1, 24);
    checks++; if (tCmd[12] !== C_BST || tCmd[15] !== C_PRE) begin errors++; $display("[TB] FAIL drop_cmds: got bst=%b pre=%b expected 0110/0010", tCmd[12], tCmd[15]); end
    ackStats(first, last, count, dataBad);
    checks++; if (count !== 8 || first !== 8 || last !== 15 || dataBad !== 0) begin errors++; $display("[TB] FAIL drop_acks: got count=%0d first=%0d last=%0d bad=%0d expected 8/8/15/0", count, first, last, dataBad); end
    endStats(endCnt, endAt);
    checks++; if (endCnt !== 1 || endAt !== 18) begin errors++; $display("[TB] FAIL drop_end: got count=%0d at=%0d expected 1 at 18", endCnt, endAt); end
  endtask

  task automatic test_back_to_back();
    int first, last, count, dataBad, endCnt, endAt;
    runRead({2'b00, 11'h3a5, 8'h12}, 9'd2, 14, 1'b0, 30);
    checks++; if (tEnd[12] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end1: got %b expected 1", tEnd[12]); end
    checks++; if (tCmd[13] !== C_NOP || tCmd[14] !== C_ACT || tAddr[14] !== 11'h3a5) begin errors++; $display("[TB] FAIL b2b_second_act: got c13=%b c14=%b addr=%h expected 0111/0011/3a5", tCmd[13], tCmd[14], tAddr[14]); end
    checks++; if (tCmd[17] !== C_RD || tAddr[17] !== 11'h012) begin errors++; $display("[TB] FAIL b2b_second_read: got cmd=%b addr=%h expected 0101/012", tCmd[17], tAddr[17]); end
    ackStats(first, last, count, dataBad);
    checks++; if (count !== 4 || dataBad !== 0) begin errors++; $display("[TB] FAIL b2b_acks: got count=%0d bad=%0d expected 4/0", count, dataBad); end
    endStats(endCnt, endAt);
    checks++; if (endCnt !== 2 || tEnd[25] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_end2: got count=%0d end25=%b expected 2/1", endCnt, tEnd[25]); end
  endtask

  task automatic test_reset_mid();
    int first, last, count, dataBad, endCnt, endAt, busy;
    runRead({2'b01, 11'h222, 8'h33}, 9'd8, -1, 1'b1, 9);
    checks++; if (tAck[9] !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_pre_ack: got %b expected 1", tAck[9]); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (rd_cmd !== C_NOP || rd_ba !== 2'b11 || rd_sdram_addr !== 11'h7ff) begin errors++; $display("[TB] FAIL rst_mid_bus: got cmd=%b ba=%b addr=%h expected 0111/11/7ff", rd_cmd, rd_ba, rd_sdram_addr); end
    checks++; if (rd_ack !== 1'b0 || rd_end !== 1'b0 || rd_sdram_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_strobes: got ack=%b end=%b data=%h expected 0/0/0", rd_ack, rd_end, rd_sdram_data); end
    rd_en = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      if (rd_ack !== 1'b0 || rd_end !== 1'b0 || rd_cmd !== C_NOP) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("[TB] FAIL rst_mid_quiet: got %0d active cycles expected 0", busy); end
    runRead({2'b10, 11'h123, 8'h40}, 9'd4, -1, 1'b1, 16);
    checks++; if (tCmd[1] !== C_ACT || tCmd[8] !== C_BST || tCmd[11] !== C_PRE) begin errors++; $display("[TB] FAIL rst_mid_rerun_cmds: got %b/%b/%b expected 0011/0110/0010", tCmd[1], tCmd[8], tCmd[11]); end
    ackStats(first, last, count, dataBad);
    checks++; if (count !== 4 || first !== 8 || dataBad !== 0) begin errors++; $display("[TB] FAIL rst_mid_rerun_acks: got count=%0d first=%0d bad=%0d expected 4/8/0", count, first, dataBad); end
    endStats(endCnt, endAt);
    checks++; if (endCnt !== 1 || endAt !== 14) begin errors++; $display("[TB] FAIL rst_mid_rerun_end: got count=%0d at=%0d expected 1 at 14", endCnt, endAt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len1();
    test_full_page(9'd256);
    test_full_page(9'd0);
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_read.md
Name: sdram_read

Overview:
- Read-side engine of the SDRAM controller and the responder to the arbiter's read grant.
- When granted via rd_en, it sequences ACTIVE -> tRCD -> READ (full-page burst) -> BURST STOP -> PRECHARGE -> tRP, then pulses rd_end.
- It samples returning data from the shared 32-bit DQ bus, while the arbiter drives the bus only for writes.
- Output data/strobe feed the read FIFO. Command/bank/address outputs go to the arbiter's READ-state mux.

Parameters:
- CL, 3, CAS latency in clocks; must match the mode register programmed at init (CL=3, full-page burst).
- TRCD_CLK, 2, NOP cycles between ACTIVE and READ.
- TRP_CLK, 2, NOP cycles after PRECHARGE.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset: asynchronous, active-low.
- init_end  in  1  initialisation complete; requests are ignored while low.
- rd_en  in  1  read grant from the arbiter; level, held until after rd_end.
- rd_addr  in  21  start address: {bank[20:19], row[18:8], col[7:0]}.
- rd_burst_len  in  9  words to read, 1..256.
- rd_data_in  in  32  SDRAM DQ bus (input sampling only).
- rd_end  out  1  one-cycle transaction-complete pulse.
- rd_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- rd_ba  out  2  bank address.
- rd_sdram_addr  out  11  SDRAM address bus.
- rd_ack  out  1  rd_sdram_data valid this cycle (FIFO write strobe).
- rd_sdram_data  out  32  registered read word.

Behaviour:
- Command encodings: NOP 0111, ACTIVE 0011, READ 0101, BURST_STOP 0110, PRECHARGE 0010.
- Reset values: rd_cmd=NOP, rd_ba=2'b11, rd_sdram_addr=11'h7ff, rd_end=0, rd_ack=0, rd_sdram_data=0, state IDLE, counters 0.
- Outputs are registered or state-decoded from registers, so there are no combinational paths from inputs.
- States: IDLE, ACTIVE, TRCD, READ, RDDATA, PRE, TRP, END (one-hot).
- IDLE: outputs hold NOP/11/7ff. If init_end && rd_en, go to ACTIVE. On that same edge latch rd_addr and rd_burst_len (0 or >256 clamps to 256) into internal registers.
- ACTIVE (1 cycle): cmd ACTIVE, ba=bank, addr=row.
- TRCD (TRCD_CLK cycles): NOP.
- READ (1 cycle): cmd READ, ba=bank, addr={3'b000,col} (A10=0, no auto-precharge). cnt_rd=0 in this cycle.
- RDDATA: cnt_rd increments each cycle.
  - Cycle with cnt_rd == len: cmd BURST_STOP; NOP otherwise.
  - Len 256 still issues BURST_STOP, since a full page wraps.
  - Leave RDDATA when cnt_rd == CL+len-1.
- DQ valid when CL <= cnt_rd <= CL+len-1.
  - Registered one cycle later: rd_ack=1 and rd_sdram_data=rd_data_in sampled the cycle before.
  - Exactly len rd_ack pulses per transaction, contiguous.
- PRE (1 cycle, at cnt_rd == CL+len): cmd PRECHARGE, addr=11'h400 (A10=1, all banks), ba=2'b00.
- TRP (TRP_CLK cycles): NOP.
- END (1 cycle): rd_end=1, NOP; then IDLE.
- rd_en deasserting mid-transaction is ignored; the sequence always completes.
- rd_en still high in the first IDLE cycle after END is not possible with the arbiter (it clears rd_en on the edge after rd_end). This block still requires rd_en to be sampled high in IDLE to start.
- Asynchronous reset mid-transaction: immediate return to reset values and IDLE. No PRECHARGE is issued; system re-initialises.
- Latency, request edge to rd_end: 1+TRCD_CLK+1+(CL+len)+1+TRP_CLK cycles. For defaults with len=4: 14 cycles after the cycle rd_en is first seen.

Decomposition:
- Shared package sdram_pkg holds:
  - command encodings (NOP/ACTIVE/READ/BURST_STOP/PRECHARGE/AUTO_REF/MRS);
  - default CL/TRCD/TRP;
  - address field widths (BA 2, ROW 11, COL 8, DQ 32);
  - idle bus values (ba 2'b11, addr 11'h7ff).
- State encoding stays local.
- No sub-module is natural; a single FSM plus two counters (cnt_clk for TRCD/TRP, cnt_rd for the burst).

Test Plan:
- Reset with init_end=0, rd_en=1 -> no activity; rd_cmd=0111, rd_ba=11, rd_sdram_addr=7ff indefinitely.
- rd_en at cycle 0, addr={2'b10, row 11'h123, col 8'h40}, len=4, model returns D0..D3 on cycles 7..10:
  - ACT ba=10/addr=123 at cycle 1;
  - READ addr=040 at cycle 4;
  - BST at cycle 8;
  - rd_ack cycles 8..11 carrying D0..D3;
  - PRE addr=400 at cycle 11;
  - rd_end at cycle 14.
- len=1 -> BST at cycle 5, single rd_ack at cycle 8, rd_end at cycle 11.
- len=256 and len=0 -> exactly 256 rd_ack pulses each, BST at cnt_rd=256, no gaps.
- rd_en dropped in cycle 3 of a len=8 read -> full sequence completes, 8 acks, one rd_end. Back-to-back rd_en after rd_end -> second ACTIVE one cycle after return to IDLE.
- sys_rst_n pulsed low during RDDATA -> outputs at reset values asynchronously, rd_ack stops, no rd_end. Next request runs a clean full sequence.
